// File: rtl/rr_arbiter_2x4_pkg.sv
// Shared encodings and sizes for the 4-requester round-robin arbiter.
package rr_arbiter_2x4_pkg;

  localparam int ARB_N = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/decoder_2x4_str.sv
// Gate-level 2-to-4 decoder with enable; y[{a,b}] is set when en is high.
module decoder_2x4_str (
  input  logic       a,
  input  logic       b,
  input  logic       en,
  output logic [3:0] y
);

  logic a_n;
  logic b_n;

  not u_not_a (a_n, a);
  not u_not_b (b_n, b);

  and u_and0 (y[0], a_n, b_n, en);
  and u_and1 (y[1], a_n, b,   en);
  and u_and2 (y[2], a,   b_n, en);
  and u_and3 (y[3], a,   b,   en);

endmodule

// File: rtl/rr_arbiter_2x4_pick.sv
// Round-robin picker: first requester after last_idx, wrapping mod 4.
module rr_pick4
  import rr_arbiter_2x4_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan farthest to nearest so the nearest pending requester wins.
  always_comb begin
    pick = last_idx;
    cand = last_idx;
    for (int k = ARB_N; k >= 1; k--) begin
      cand = last_idx + IDX_W'(k);
      if (req[cand]) pick = cand;
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arbiter_2x4.sv
// Round-robin arbiter for 4 requesters with one-hot grant via a 2x4 decoder.
// Optional forced handoff after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_2x4
  import rr_arbiter_2x4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ARB_N-1:0] req,
  output logic [ARB_N-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_bad_cfg
    $error("rr_arbiter_2x4: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [ARB_N-1:0] owner_mask;
  logic [ARB_N-1:0] pick_req;
  logic [IDX_W-1:0] pick_last;
  logic [IDX_W-1:0] pick;
  logic             pick_any;
  logic             release_now;
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             hold_expired;
`endif

  // While granting, the owner is masked so a handoff always moves on.
  assign owner_mask = ARB_N'(1) << idx_q;
  assign pick_req   = (state_q == ST_GRANT) ? (req & ~owner_mask) : req;
  assign pick_last  = (state_q == ST_GRANT) ? idx_q : last_q;

  rr_pick4 u_pick (
    .req      (pick_req),
    .last_idx (pick_last),
    .pick     (pick),
    .any      (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_expired = (hold_q == CNT_W'(MAX_HOLD - 1));
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          idx_d   = pick;
          valid_d = 1'b1;
        end
      end
      ST_GRANT: begin
        release_now = !req[idx_q];
`ifdef ARB_TIMEOUT_EN
        if (hold_expired && pick_any) release_now = 1'b1;
`endif
        if (release_now) begin
          last_d = idx_q;
          if (pick_any) begin
            idx_d = pick;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
      end
    endcase
`ifdef ARB_TIMEOUT_EN
    // Counter only runs while the same owner keeps the grant.
    if (state_q == ST_GRANT && !release_now)
      hold_d = hold_expired ? '0 : hold_q + CNT_W'(1);
    else
      hold_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(ARB_N - 1);
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`endif

  decoder_2x4_str u_dec (
    .a  (idx_q[1]),
    .b  (idx_q[0]),
    .en (valid_q),
    .y  (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_2x4.sv
// Scoreboard bench for rr_arbiter_2x4: directed rows queue expectations,
// a monitor pops them after each edge and also checks one-hot and fairness.
module tb_rr_arbiter_2x4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int num_checks = 0;
  int num_fails  = 0;
  int tag_cnt    = 0;
  int waits[4];

  typedef struct packed {
    logic [3:0]  gnt;
    logic        valid;
    logic [1:0]  idx;
    logic [15:0] tag;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter_2x4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] expv);
    num_checks++;
    if (act !== expv) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic pushExp(input logic [3:0] g, input logic v, input logic [1:0] i);
    exp_t e;
    e.gnt   = g;
    e.valid = v;
    e.idx   = i;
    e.tag   = 16'(tag_cnt);
    tag_cnt++;
    exp_q.push_back(e);
  endtask

  // Drive one request vector; expectation applies right after the next rising edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] g, input logic v,
                               input logic [1:0] i);
    @(negedge clk);
    req = r;
    pushExp(g, v, i);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] exp_dec;
    logic [1:0] prev_idx;
    logic       prev_valid;
    prev_idx   = '0;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) waits[i] = 0;
        prev_valid = 1'b0;
      end else begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput($sformatf("row%0d gnt", e.tag), 8'(gnt), 8'(e.gnt));
          checkOutput($sformatf("row%0d gnt_valid", e.tag), 8'(gnt_valid), 8'(e.valid));
          checkOutput($sformatf("row%0d gnt_idx", e.tag), 8'(gnt_idx), 8'(e.idx));
        end
        checkOutput("gnt onehot0", 8'($onehot0(gnt)), 8'd1);
        exp_dec = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
        checkOutput("gnt vs decode(gnt_idx)", 8'(gnt), 8'(exp_dec));
        for (int i = 0; i < 4; i++) if (!req[i]) waits[i] = 0;
        if (gnt_valid && (!prev_valid || gnt_idx != prev_idx)) begin
          for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
              if (gnt_idx == 2'(i)) waits[i] = 0;
              else waits[i]++;
              checkOutput($sformatf("fair req%0d waited %0d grants", i, waits[i]),
                          8'(waits[i] > 3), 8'd0);
            end
          end
        end
        prev_valid = gnt_valid;
        prev_idx   = gnt_idx;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] nreq;
    logic [3:0] g;
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset gnt", 8'(gnt), 8'd0);
    checkOutput("reset gnt_valid", 8'(gnt_valid), 8'd0);
    checkOutput("reset gnt_idx", 8'(gnt_idx), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rotation with all requesting; each owner drops one cycle after grant.
    applyStimulus(4'b1111, 4'b0001, 1'b1, 2'd0);
    applyStimulus(4'b1110, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b1100, 4'b0100, 1'b1, 2'd2);
    applyStimulus(4'b1000, 4'b1000, 1'b1, 2'd3);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 2'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd0);

    // Single requester holds the grant, then releases to idle.
    applyStimulus(4'b0100, 4'b0100, 1'b1, 2'd2);
    repeat (20) applyStimulus(4'b0100, 4'b0100, 1'b1, 2'd2);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd2);

    // Owner 1 releases with 0 and 3 pending: 3 is next, no bubble.
    applyStimulus(4'b0010, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b1011, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b1001, 4'b1000, 1'b1, 2'd3);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 2'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd0);

    // Wrap-around pick from owner 1 to requester 0.
    applyStimulus(4'b0010, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b0011, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 2'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd0);

    // Asynchronous reset between edges while granting.
    applyStimulus(4'b0100, 4'b0100, 1'b1, 2'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset gnt", 8'(gnt), 8'd0);
    checkOutput("async reset gnt_valid", 8'(gnt_valid), 8'd0);
    checkOutput("async reset gnt_idx", 8'(gnt_idx), 8'd0);
    @(negedge clk);
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    pushExp(4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b1010, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b1000, 4'b1000, 1'b1, 2'd3);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd3);

`ifdef ARB_TIMEOUT_EN
    // Two persistent requesters alternate every 8 cycles.
    for (int k = 0; k < 24; k++) begin
      g = (((k / 8) % 2) == 0) ? 4'b0001 : 4'b0010;
      applyStimulus(4'b0011, g, 1'b1, (g == 4'b0001) ? 2'd0 : 2'd1);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd0);
`endif

    // Random traffic: requests held until served, owners drop at random.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      nreq = req;
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (gnt_valid && gnt_idx == 2'(i) && $urandom_range(2) == 0) nreq[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          nreq[i] = 1'b1;
        end
      end
      req = nreq;
    end
    @(negedge clk);
    req = 4'b0000;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("scoreboard drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
